il2_cache: RTL and testbench

- Read-only, 2-way set-associative instruction L2 cache between the L1 instruction cache's 128-bit block-fill port and main memory.
- Serves full 128-bit blocks to the L1 on hit.
- On miss, fetches the block from memory, fills the LRU/invalid way, then responds.
- Tracks one outstanding request; no write path.

---
 rtl/il2_pkg.sv | 22 ++
 rtl/il2_way.sv | 45 ++++
 rtl/il2_cache.sv | 155 +++++++++++++++
 tb/tb_il2_cache.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/il2_pkg.sv
// Shared types and constants for the il2 instruction L2 cache.
// The optional IL2_PERF_CNT_EN build is handled in il2_cache; nothing here depends on it.
package il2_pkg;
   localparam int BLOCK_W = 128;
   localparam int ADDR_W  = 30;
   localparam int DEF_SET_OFFSET = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      MISS   = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Word address minus the two block-offset bits minus the index bits.
   function automatic int tag_w(input int set_offset);
      return ADDR_W - 2 - set_offset;
   endfunction

   localparam int DEF_TAG_W = ADDR_W - 2 - DEF_SET_OFFSET;
   localparam int DEF_IDX_W = DEF_SET_OFFSET;
endpackage

// File: rtl/il2_way.sv
// One way of the il2 cache: valid/tag/data arrays, one write port, async read.
module il2_way
   import il2_pkg::*;
#(
   parameter int NUM_OF_SET = 32,
   parameter int SET_OFFSET = 5,
   parameter int TAG_W      = ADDR_W - 2 - SET_OFFSET
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [SET_OFFSET-1:0] w_idx,
   input  logic [TAG_W-1:0]      w_tag,
   input  logic [BLOCK_W-1:0]    w_data,
   input  logic [SET_OFFSET-1:0] r_idx,
   output logic                  r_valid,
   output logic [TAG_W-1:0]      r_tag,
   output logic [BLOCK_W-1:0]    r_data
);
   logic [NUM_OF_SET-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]      tag_q  [NUM_OF_SET];
   logic [BLOCK_W-1:0]    data_q [NUM_OF_SET];

   always_comb begin
      valid_d = valid_q;
      if (we) valid_d[w_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Tag and data contents are meaningless until valid is set, so they are not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[w_idx]  <= w_tag;
         data_q[w_idx] <= w_data;
      end
   end

   assign r_valid = valid_q[r_idx];
   assign r_tag   = tag_q[r_idx];
   assign r_data  = data_q[r_idx];
endmodule

// File: rtl/il2_cache.sv
// Read-only 2-way set-associative instruction L2 cache with a single outstanding request.
// Define IL2_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module il2_cache
   import il2_pkg::*;
#(
   parameter int NUM_OF_SET = 32,
   parameter int SET_OFFSET = 5
) (
   input  logic               clk,
   input  logic               proc_reset_n,
   input  logic               l1_read,
   input  logic [ADDR_W-1:0]  l1_addr,
   output logic [BLOCK_W-1:0] l1_rdata,
   output logic               l1_ready,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [BLOCK_W-1:0] mem_wdata,
   input  logic [BLOCK_W-1:0] mem_rdata,
   input  logic               mem_ready
`ifdef IL2_PERF_CNT_EN
   ,
   output logic [31:0]        hit_cnt,
   output logic [31:0]        miss_cnt
`endif
);
   localparam int TAG_W = ADDR_W - 2 - SET_OFFSET;

   state_t                state_q, state_d;
   logic [TAG_W-1:0]      req_tag_q, req_tag_d;
   logic [SET_OFFSET-1:0] req_idx_q, req_idx_d;
   logic [NUM_OF_SET-1:0] lru_q, lru_d;
   logic [BLOCK_W-1:0]    fill_buf_q, fill_buf_d;
   logic                  hold_q, hold_d;

   logic                  v0, v1, hit0, hit1, victim, fill_we, hit_evt, miss_evt;
   logic [TAG_W-1:0]      t0, t1;
   logic [BLOCK_W-1:0]    d0, d1;

   il2_way #(.NUM_OF_SET(NUM_OF_SET), .SET_OFFSET(SET_OFFSET), .TAG_W(TAG_W)) u_way0 (
      .clk(clk), .rst_n(proc_reset_n), .we(fill_we & ~victim), .w_idx(req_idx_q),
      .w_tag(req_tag_q), .w_data(mem_rdata), .r_idx(req_idx_q),
      .r_valid(v0), .r_tag(t0), .r_data(d0));

   il2_way #(.NUM_OF_SET(NUM_OF_SET), .SET_OFFSET(SET_OFFSET), .TAG_W(TAG_W)) u_way1 (
      .clk(clk), .rst_n(proc_reset_n), .we(fill_we & victim), .w_idx(req_idx_q),
      .w_tag(req_tag_q), .w_data(mem_rdata), .r_idx(req_idx_q),
      .r_valid(v1), .r_tag(t1), .r_data(d1));

   assign hit0   = v0 && (t0 == req_tag_q);
   assign hit1   = v1 && (t1 == req_tag_q);
   // Invalid ways are filled first; lru_q[idx] names the least recently used way.
   assign victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[req_idx_q]);

   assign mem_write = 1'b0;
   assign mem_wdata = '0;

   always_comb begin
      state_d    = state_q;
      req_tag_d  = req_tag_q;
      req_idx_d  = req_idx_q;
      lru_d      = lru_q;
      fill_buf_d = fill_buf_q;
      hold_d     = hold_q & l1_read;
      l1_ready   = 1'b0;
      l1_rdata   = '0;
      mem_read   = 1'b0;
      mem_addr   = '0;
      fill_we    = 1'b0;
      hit_evt    = 1'b0;
      miss_evt   = 1'b0;
      case (state_q)
         IDLE: begin
            if (l1_read && !hold_q) begin
               req_tag_d = l1_addr[ADDR_W-1:2+SET_OFFSET];
               req_idx_d = l1_addr[1+SET_OFFSET:2];
               state_d   = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit0 || hit1) begin
               hit_evt           = 1'b1;
               l1_ready          = 1'b1;
               l1_rdata          = hit0 ? d0 : d1;
               lru_d[req_idx_q]  = hit0;
               state_d           = IDLE;
            end else begin
               miss_evt = 1'b1;
               state_d  = MISS;
            end
         end
         MISS: begin
            mem_read = 1'b1;
            mem_addr = {req_tag_q, req_idx_q, 2'b00};
            if (mem_ready) begin
               fill_we          = 1'b1;
               fill_buf_d       = mem_rdata;
               lru_d[req_idx_q] = ~victim;
               state_d          = RESP;
            end
         end
         RESP: begin
            l1_ready = 1'b1;
            l1_rdata = fill_buf_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // The L1 sees l1_ready a cycle late, so a still-high l1_read right after
      // a response is the old request, not a new one.
      if (l1_ready) hold_d = 1'b1;
   end

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state_q    <= IDLE;
         req_tag_q  <= '0;
         req_idx_q  <= '0;
         lru_q      <= '0;
         fill_buf_q <= '0;
         hold_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_tag_q  <= req_tag_d;
         req_idx_q  <= req_idx_d;
         lru_q      <= lru_d;
         fill_buf_q <= fill_buf_d;
         hold_q     <= hold_d;
      end
   end

`ifdef IL2_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit_evt && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_d  = hit_cnt_q + 32'd1;
      if (miss_evt && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_il2_cache.sv
// Self-checking bench for il2_cache: directed scenarios plus random traffic against a
// recency-list model of a 2-way LRU cache.
module tb_il2_cache;
   logic         clk;
   logic         proc_reset_n;
   logic         l1_read;
   logic [29:0]  l1_addr;
   logic [127:0] l1_rdata;
   logic         l1_ready;
   logic         mem_read;
   logic         mem_write;
   logic [29:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
`ifdef IL2_PERF_CNT_EN
   logic [31:0]  hit_cnt;
   logic [31:0]  miss_cnt;
`endif

   il2_cache dut (
      .clk(clk), .proc_reset_n(proc_reset_n), .l1_read(l1_read), .l1_addr(l1_addr),
      .l1_rdata(l1_rdata), .l1_ready(l1_ready), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef IL2_PERF_CNT_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: per set, a most-recent-first list of up to two block addresses
   logic [27:0]  m_blk [32][2];
   logic [127:0] m_dat [32][2];
   int           m_cnt [32];
   int           m_hits, m_misses;
   logic [127:0] exp_q [$];

   task automatic model_clear();
      for (int s = 0; s < 32; s++) m_cnt[s] = 0;
      m_hits = 0;
      m_misses = 0;
   endtask

   task automatic model_access(input logic [29:0] a, input logic [127:0] fill,
                               output bit hit, output logic [127:0] d);
      int s;
      logic [27:0] blk;
      s = int'(a[6:2]);
      blk = a[29:2];
      hit = 0;
      d = '0;
      for (int i = 0; i < m_cnt[s]; i++) begin
         if (!hit && m_blk[s][i] == blk) begin
            hit = 1;
            d = m_dat[s][i];
            if (i == 1) begin
               m_blk[s][1] = m_blk[s][0];
               m_dat[s][1] = m_dat[s][0];
               m_blk[s][0] = blk;
               m_dat[s][0] = d;
            end
         end
      end
      if (!hit) begin
         m_blk[s][1] = m_blk[s][0];
         m_dat[s][1] = m_dat[s][0];
         m_blk[s][0] = blk;
         m_dat[s][0] = fill;
         if (m_cnt[s] < 2) m_cnt[s]++;
         d = fill;
         m_misses++;
      end else begin
         m_hits++;
      end
   endtask

   // driver: one L1 request with a memory responder; records what it observed
   int           obs_lat, obs_rdy, obs_mrd, obs_abad;
   bit           obs_to;
   logic [127:0] obs_data;

   task automatic do_req(input logic [29:0] a, input int delay, input logic [127:0] fill,
                         input bit hold);
      logic [29:0] exp_ma;
      bit done;
      exp_ma = {a[29:2], 2'b00};
      obs_lat = 0; obs_rdy = 0; obs_mrd = 0; obs_abad = 0; obs_to = 0; obs_data = '0;
      done = 0;
      @(negedge clk);
      l1_read = 1'b1;
      l1_addr = a;
      for (int c = 1; c <= 80 && !done; c++) begin
         @(posedge clk); #1;
         mem_ready = 1'b0;
         if (mem_read) begin
            obs_mrd++;
            if (mem_addr !== exp_ma) obs_abad++;
            if (obs_mrd == delay) begin
               mem_ready = 1'b1;
               mem_rdata = fill;
            end
         end
         if (l1_ready) begin
            obs_rdy++;
            obs_data = l1_rdata;
            obs_lat = c;
            done = 1;
         end
      end
      if (!done) obs_to = 1;
      if (!hold) l1_read = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         mem_ready = 1'b0;
         if (k == 1) l1_read = 1'b0;
         if (mem_read) obs_mrd++;
         if (l1_ready) obs_rdy++;
      end
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic test_reset();
      proc_reset_n = 1'b0;
      l1_read = 1'b0;
      l1_addr = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      model_clear();
      #1;
      total++; if (l1_ready !== 1'b0) begin bad++; $display("FAIL reset_l1_ready got=%0b want=0", l1_ready); end
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%0b want=0", mem_read); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      proc_reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (l1_rdata !== 128'h0) begin bad++; $display("FAIL reset_l1_rdata got=%h want=0", l1_rdata); end
      total++; if (mem_addr !== 30'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
      total++; if ({mem_write, mem_wdata} !== 129'h0) begin bad++; $display("FAIL reset_mem_write got=%0b/%h want=0", mem_write, mem_wdata); end
   endtask

   // cold miss then same-block hit, and the conflict/LRU sequence, from one table
   task automatic test_directed();
      logic [29:0]  addrs [8];
      int           dlys  [8];
      logic [127:0] fill, exp_d;
      bit           hit;
      addrs = '{30'h40, 30'h42, 30'h1040, 30'h40, 30'h2040, 30'h40, 30'h1040, 30'h40};
      dlys  = '{5, 2, 3, 1, 4, 2, 1, 3};
      for (int i = 0; i < 8; i++) begin
         fill = (i == 0) ? 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001
                         : {$urandom, $urandom, $urandom, $urandom};
         model_access(addrs[i], fill, hit, exp_d);
         do_req(addrs[i], dlys[i], fill, 1'b0);
         total++; if (obs_to) begin bad++; $display("FAIL dir%0d_timeout got=no_ready want=ready", i); end
         total++; if (obs_lat != (hit ? 1 : 2 + dlys[i])) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, obs_lat, hit ? 1 : 2 + dlys[i]); end
         total++; if (obs_mrd != (hit ? 0 : dlys[i])) begin bad++; $display("FAIL dir%0d_mem_read_cycles got=%0d want=%0d", i, obs_mrd, hit ? 0 : dlys[i]); end
         total++; if (obs_abad != 0) begin bad++; $display("FAIL dir%0d_mem_addr bad_cycles=%0d want=0", i, obs_abad); end
         total++; if (obs_rdy != 1) begin bad++; $display("FAIL dir%0d_ready_pulses got=%0d want=1", i, obs_rdy); end
         total++; if (obs_data !== exp_d) begin bad++; $display("FAIL dir%0d_data got=%h want=%h", i, obs_data, exp_d); end
      end
   endtask

   task automatic test_reset_mid_miss();
      logic [127:0] fill, exp_d;
      bit hit, seen;
      seen = 0;
      @(negedge clk);
      l1_read = 1'b1;
      l1_addr = 30'h0000_3040;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (mem_read) seen = 1;
      end
      total++; if (!seen) begin bad++; $display("FAIL midmiss_enter got=no_mem_read want=mem_read"); end
      #2;
      proc_reset_n = 1'b0;
      #1;
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL midmiss_async_mem_read got=%0b want=0", mem_read); end
      total++; if (l1_ready !== 1'b0) begin bad++; $display("FAIL midmiss_async_l1_ready got=%0b want=0", l1_ready); end
      total++; if (mem_addr !== 30'h0) begin bad++; $display("FAIL midmiss_async_mem_addr got=%h want=0", mem_addr); end
      l1_read = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      proc_reset_n = 1'b1;
      fill = {$urandom, $urandom, $urandom, $urandom};
      model_access(30'h40, fill, hit, exp_d);
      do_req(30'h40, 2, fill, 1'b0);
      total++; if (obs_mrd != (hit ? 0 : 2)) begin bad++; $display("FAIL midmiss_refetch got=%0d want=%0d", obs_mrd, hit ? 0 : 2); end
      total++; if (obs_data !== exp_d) begin bad++; $display("FAIL midmiss_data got=%h want=%h", obs_data, exp_d); end
   endtask

   task automatic test_spurious_and_hold();
      logic [127:0] fill, exp_d;
      bit hit;
      int errs;
      errs = 0;
      @(negedge clk);
      l1_read = 1'b0;
      for (int c = 0; c < 3; c++) begin
         mem_ready = 1'b1;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         if (l1_ready || mem_read) errs++;
      end
      mem_ready = 1'b0;
      total++; if (errs != 0) begin bad++; $display("FAIL spurious_mem_ready activity_cycles=%0d want=0", errs); end
      for (int i = 0; i < 2; i++) begin
         fill = {$urandom, $urandom, $urandom, $urandom};
         model_access(i == 0 ? 30'h40 : 30'h0000_5004, fill, hit, exp_d);
         do_req(i == 0 ? 30'h40 : 30'h0000_5004, 2, fill, 1'b1);
         total++; if (obs_rdy != 1) begin bad++; $display("FAIL hold%0d_ready_pulses got=%0d want=1", i, obs_rdy); end
         total++; if (obs_mrd != (hit ? 0 : 2)) begin bad++; $display("FAIL hold%0d_mem_read_cycles got=%0d want=%0d", i, obs_mrd, hit ? 0 : 2); end
         total++; if (obs_data !== exp_d) begin bad++; $display("FAIL hold%0d_data got=%h want=%h", i, obs_data, exp_d); end
      end
   endtask

   task automatic test_random();
      logic [29:0]  a;
      logic [127:0] fill, exp_d, want;
      bit           hit;
      int           dly;
      logic [4:0]   idx_tab [3];
      idx_tab = '{5'd0, 5'd16, 5'd5};
      for (int i = 0; i < 40; i++) begin
         a = {21'h0, 2'($urandom_range(0, 3)), idx_tab[$urandom_range(0, 2)], 2'($urandom_range(0, 3))};
         dly = $urandom_range(1, 4);
         fill = {$urandom, $urandom, $urandom, $urandom};
         model_access(a, fill, hit, exp_d);
         exp_q.push_back(exp_d);
         do_req(a, dly, fill, 1'($urandom_range(0, 1)));
         want = exp_q.pop_front();
         total++; if (obs_data !== want) begin bad++; $display("FAIL rnd%0d_data addr=%h got=%h want=%h", i, a, obs_data, want); end
         total++; if (obs_lat != (hit ? 1 : 2 + dly)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, obs_lat, hit ? 1 : 2 + dly); end
         total++; if (obs_mrd != (hit ? 0 : dly) || obs_abad != 0) begin bad++; $display("FAIL rnd%0d_mem got=%0d/%0d want=%0d/0", i, obs_mrd, obs_abad, hit ? 0 : dly); end
         total++; if (obs_rdy != 1) begin bad++; $display("FAIL rnd%0d_ready_pulses got=%0d want=1", i, obs_rdy); end
      end
`ifdef IL2_PERF_CNT_EN
      total++; if (hit_cnt !== 32'(m_hits)) begin bad++; $display("FAIL perf_hit_cnt got=%0d want=%0d", hit_cnt, m_hits); end
      total++; if (miss_cnt !== 32'(m_misses)) begin bad++; $display("FAIL perf_miss_cnt got=%0d want=%0d", miss_cnt, m_misses); end
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_miss();
      test_spurious_and_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
